// File: rtl/mdr_result_pkg.sv
// Shared constants for the arithmetic result collector: selection modes,
// channel numbering of the existing arithmetic units, and the default width.
package mdr_result_pkg;

   // Selection modes for the output stage
   localparam logic MODE_DIRECTED    = 1'b0;
   localparam logic MODE_ROUND_ROBIN = 1'b1;

   // Channel indices of the existing arithmetic units
   localparam int CH_MULT = 0;
   localparam int CH_DIV  = 1;
   localparam int CH_SQR  = 2;

   // Default result width
   localparam int DEFAULT_NBITS = 16;

endpackage : mdr_result_pkg

// File: rtl/result_collector_mux_rr_picker.sv
// Round-robin picker: finds the first requesting channel after lastGrant,
// wrapping modulo NChannels. Purely combinational.
module rr_picker #(
   parameter int NChannels = 3,
   parameter int SelBits   = (NChannels > 1) ? $clog2(NChannels) : 1
) (
   input  logic [NChannels-1:0] req,
   input  logic [SelBits-1:0]   lastGrant,
   output logic [SelBits-1:0]   grant,
   output logic                 grantValid
);

   int idx_s;

   // Search lastGrant+1, +2, ... with wrap; the first hit wins
   always_comb begin
      grant      = {SelBits{1'b0}};
      grantValid = 1'b0;
      idx_s      = 0;
      for (int k = 1; k <= NChannels; k++) begin
         idx_s = (int'(lastGrant) + k) % NChannels;
         if (!grantValid && req[idx_s]) begin
            grantValid = 1'b1;
            grant      = idx_s[SelBits-1:0];
         end else begin
            grantValid = grantValid;
         end
      end
   end

endmodule : rr_picker

// File: rtl/result_collector_mux.sv
// Registered result collector: latches each arithmetic unit's one-cycle
// result pulse and delivers the held results one at a time on a
// valid/ready port, either by external selection or round-robin.
module result_collector_mux
   import mdr_result_pkg::*;
#(
   parameter int NBits     = DEFAULT_NBITS,
   parameter int NChannels = 3,
   localparam int SelBits  = $clog2(NChannels)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       Mode,
   input  logic [SelBits-1:0]         Selector,
   input  logic [NChannels-1:0]       In_Valid,
   input  logic [NChannels*NBits-1:0] In_Data,
   input  logic                       Out_Ready,
   output logic                       Out_Valid,
   output logic [NBits-1:0]           Out_Data,
   output logic [SelBits-1:0]         Out_Channel,
   output logic [NChannels-1:0]       Pending,
   output logic [NChannels-1:0]       Overrun
);

   logic [NBits-1:0]     held_r [NChannels];
   logic [NChannels-1:0] pending_r;
   logic [NChannels-1:0] overrun_r;
   logic                 outValid_r;
   logic [NBits-1:0]     outData_r;
   logic [SelBits-1:0]   outChannel_r;
   logic [SelBits-1:0]   lastGrant_r;

   logic [SelBits-1:0]   rrGrant_s;
   logic                 rrValid_s;
   logic                 dirValid_s;
   logic [SelBits-1:0]   cand_s;
   logic                 candValid_s;
   logic                 stageFree_s;
   logic                 loadEn_s;

   rr_picker #(
      .NChannels (NChannels),
      .SelBits   (SelBits)
   ) u_rrPicker (
      .req        (pending_r),
      .lastGrant  (lastGrant_r),
      .grant      (rrGrant_s),
      .grantValid (rrValid_s)
   );

   // Directed candidate: an out-of-range Selector matches no channel
   always_comb begin
      dirValid_s = 1'b0;
      for (int i = 0; i < NChannels; i++) begin
         if ((Selector == SelBits'(i)) && pending_r[i]) begin
            dirValid_s = 1'b1;
         end else begin
            dirValid_s = dirValid_s;
         end
      end
   end

   // Choose the candidate for this edge and decide whether it loads
   always_comb begin
      cand_s      = Selector;
      candValid_s = dirValid_s;
      if (Mode == MODE_ROUND_ROBIN) begin
         cand_s      = rrGrant_s;
         candValid_s = rrValid_s;
      end else begin
         cand_s      = Selector;
         candValid_s = dirValid_s;
      end
      stageFree_s = !outValid_r || Out_Ready;
      loadEn_s    = stageFree_s && candValid_s;
   end

   // Holding registers, pending/overrun flags, output stage and arbiter state
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NChannels; i++) begin
            held_r[i] <= {NBits{1'b0}};
         end
         pending_r    <= {NChannels{1'b0}};
         overrun_r    <= {NChannels{1'b0}};
         outValid_r   <= 1'b0;
         outData_r    <= {NBits{1'b0}};
         outChannel_r <= {SelBits{1'b0}};
         lastGrant_r  <= SelBits'(NChannels - 1);
      end else begin
         // A channel being loaded this edge frees its slot for a new capture
         for (int i = 0; i < NChannels; i++) begin
            if (In_Valid[i]) begin
               if (!pending_r[i] || (loadEn_s && (cand_s == SelBits'(i)))) begin
                  held_r[i]    <= In_Data[i*NBits +: NBits];
                  pending_r[i] <= 1'b1;
               end else begin
                  overrun_r[i] <= 1'b1;
               end
            end else if (loadEn_s && (cand_s == SelBits'(i))) begin
               pending_r[i] <= 1'b0;
            end else begin
               pending_r[i] <= pending_r[i];
            end
         end

         if (loadEn_s) begin
            outValid_r   <= 1'b1;
            outData_r    <= held_r[cand_s];
            outChannel_r <= cand_s;
         end else if (stageFree_s) begin
            outValid_r   <= 1'b0;
         end else begin
            outValid_r   <= outValid_r;
         end

         if (loadEn_s && (Mode == MODE_ROUND_ROBIN)) begin
            lastGrant_r <= cand_s;
         end else begin
            lastGrant_r <= lastGrant_r;
         end
      end
   end

   assign Out_Valid   = outValid_r;
   assign Out_Data    = outData_r;
   assign Out_Channel = outChannel_r;
   assign Pending     = pending_r;
   assign Overrun     = overrun_r;

endmodule : result_collector_mux

// File: doc/result_collector_mux.md
Name: result_collector_mux

Overview:
- Parametrised, registered successor to the combinational 3:1 result select for the arithmetic units (MULT, DIV, SQR and future units).
- Captures each unit's one-cycle result pulse in a per-channel holding register.
- Delivers held results one at a time on a valid/ready output port.
- Two selection modes: directed (external Selector) or round-robin arbitration. Sits between the arithmetic units and the result/display path.

Parameters:
- NBits, 16, data width of every channel and of the output.
- NChannels, 3, number of result channels (>=2).
- SelBits (localparam), $clog2(NChannels), width of channel index ports.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Mode  input  1  0 = directed (use Selector), 1 = round-robin
- Selector  input  SelBits  channel to deliver in directed mode
- In_Valid  input  NChannels  per-channel one-cycle result strobe
- In_Data  input  NChannels*NBits  packed results; channel i at [i*NBits +: NBits]
- Out_Ready  input  1  consumer accepts Out_Data this cycle
- Out_Valid  output  1  Out_Data/Out_Channel hold a result
- Out_Data  output  NBits  delivered result
- Out_Channel  output  SelBits  source channel of Out_Data
- Pending  output  NChannels  holding register i full
- Overrun  output  NChannels  sticky: result on channel i was dropped

Behaviour:
- Reset: synchronous, active-high. On any edge with reset=1, clear all outputs, Pending, Overrun and holding registers to 0; set last_grant to NChannels-1. Applies mid-operation: in-flight data discarded, nothing delivered afterwards.
- Capture: on an edge with In_Valid[i]=1:
  - If Pending[i]=0, or channel i is loaded into the output stage on the same edge: store In_Data[i], Pending[i]=1.
  - Otherwise: keep the old data, drop the new, set Overrun[i]=1 (sticky until reset).
- Output stage is free when Out_Valid=0 or Out_Ready=1.
- Load: on each edge where the output stage is free and a candidate exists:
  - Out_Data <= held[c], Out_Channel <= c, Out_Valid <= 1, Pending[c] cleared (unless re-captured on the same edge).
  - Round-robin mode also sets last_grant <= c.
- Clear: if the output stage is free and there is no candidate, Out_Valid <= 0; Out_Data and Out_Channel retain their last values.
- Hold: while Out_Valid=1 and Out_Ready=0, Out_Data and Out_Channel are stable.
- Candidate, directed mode: c = Selector if Selector < NChannels and Pending[Selector]=1; otherwise none. An out-of-range Selector never produces output, matching the zero default of the old select.
- Candidate, round-robin mode: the first pending channel found searching last_grant+1, +2, … with wrap modulo NChannels. last_grant is updated only in round-robin mode.
- Latency: In_Valid at edge t, then Pending at t+1, then Out_Valid at t+2 earliest. Throughput is one result per cycle with Out_Ready held at 1.
- Mode or Selector changes take effect on the next load decision. Held data is never lost by a mode change.
- No arithmetic on data: pure transport, width NBits throughout.

Decomposition:
- Package mdr_result_pkg holds:
  - mode constants MODE_DIRECTED=1'b0, MODE_ROUND_ROBIN=1'b1
  - channel indices CH_MULT=0, CH_DIV=1, CH_SQR=2
  - default NBits=16
- One sub-module, rr_picker: combinational. Inputs: request vector and last_grant. Outputs: grant index and grant_valid (rotate, priority-encode, un-rotate).

Test Plan (NBits=16, NChannels=3):
- Reset: reset=1 for 2 cycles with random In_Valid/In_Data → Out_Valid, Out_Data, Out_Channel, Pending, Overrun all 0; no Out_Valid until new input after release.
- Directed: Mode=0, Selector=1, Out_Ready=1, In_Valid=3'b010, data 16'h00A5 at edge t → Pending=3'b010 at t+1; at t+2 Out_Valid=1, Out_Data=16'h00A5, Out_Channel=1, Pending=0; Out_Valid=0 at t+3.
- Round-robin: Mode=1, Out_Ready=1, In_Valid=3'b111 with 16'h1111/16'h2222/16'h3333 at t → ch0, ch1, ch2 delivered at t+2, t+3, t+4. Next single request on ch0 → delivered.
- Back-pressure/overrun: Out_Ready=0 with ch2 in output stage and ch0 pending 16'hBEEF. Second In_Valid[0] with 16'hDEAD → Overrun=3'b001, Out_Data stable for 5 cycles. Then Out_Ready=1 → ch2, then 16'hBEEF, delivered.
- Out-of-range/mode switch: Mode=0, Selector=2'b11, ch1 pending 16'h0042 → Out_Valid stays 0 for 10 cycles. Set Mode=1 → Out_Data=16'h0042, Out_Channel=1 two edges later.
- Reset mid-operation: ch0 and ch1 pending, Out_Valid=1, Out_Ready=0, assert reset 1 cycle → all cleared next edge; neither result delivered afterwards.
